sumador_segmentado: RTL and testbench
=====================================

// Module: sumador_segmentado
// PURPOSE
//   Pipelined, parametrised add/subtract unit; successor to the single-cycle 32-bit adder.
//   Splits a WIDTH-bit operation into STAGES equal slices, one slice per register stage.
//   The carry ripples between stages. Operands march with it.
//   Valid/ready handshake with backpressure; adds carry, signed-overflow and zero flags.
//   Serves the datapath for PC+4, branch targets (BNE) and ALU add/sub.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//   STAGES  2   pipeline depth = number of WIDTH/STAGES-bit slices (1..WIDTH)
// PORTS
//   clk        in   1      rising-edge clock, single clock domain
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      A/B/sub valid this cycle
//   in_ready   out  1      unit accepts the operand set this cycle
//   A          in   WIDTH  first operand
//   B          in   WIDTH  second operand
//   sub        in   1      0: O=A+B; 1: O=A-B (two's complement)
//   out_valid  out  1      O and flags hold a finished result
//   out_ready  in   1      consumer takes the result this cycle
//   O          out  WIDTH  result, modulo 2^WIDTH
//   carry      out  1      carry out of MSB (for sub: 1 = no borrow)
//   overflow   out  1      signed overflow of the add/sub
//   zero       out  1      O == 0
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): all stage valids, O, carry, overflow and zero = 0.
//     In-flight operations are discarded and never emerge. in_ready=1 the cycle after reset.
//   - Stall/advance rule: adv = !out_valid | out_ready.
//     in_ready = adv; all stages shift together when adv=1.
//     When adv=0 every stage holds and nothing is lost or duplicated.
//   - Accept = in_valid & in_ready; deliver = out_valid & out_ready.
//   - Stage 0 latches A, B'=sub?~B:B, cin=sub, and computes slice 0 sum and carry.
//   - Stage k (1..STAGES-1) adds slice k of the carried operands plus the stage k-1 carry.
//     Lower result slices are passed through unchanged.
//   - Latency: a result accepted at edge n has out_valid=1 after edge n+STAGES-1.
//     This holds without stalls; STAGES=1 gives 1-cycle registered output.
//   - Throughput: 1 op/cycle while out_ready=1. Up to STAGES ops in flight.
//   - Bubbles (in_valid=0) propagate as invalid stages. Data in invalid stages is don't-care.
//     Outputs hold their last value while out_valid=0.
//   - overflow = (A[MSB] == B'[MSB]) & (O[MSB] != A[MSB]).
//     zero is computed on the final O. All flags are registered with O.
//   - Simultaneous deliver and accept with a full pipeline is legal. Both happen in the same cycle.
//   - Outputs are stable while out_valid=1 & out_ready=0.
//   - rst_n=0 overrides in_valid and out_ready in the same cycle.
// TESTING
//   1. WIDTH=32,STAGES=2: A=0x00000004,B=0x00400000,sub=0
//      -> 2 edges later out_valid=1, O=0x00400004, carry=0, ovf=0, zero=0.
//   2. Carry across slice boundary: A=0x0000FFFF,B=0x00000001,sub=0
//      -> O=0x00010000, carry=0; A=0xFFFFFFFF,B=1 -> O=0, carry=1, zero=1.
//   3. Sub/overflow: A=0x7FFFFFFF,B=0xFFFFFFFF,sub=1 -> O=0x80000000, ovf=1, carry=0.
//      A=5,B=5,sub=1 -> O=0, zero=1, carry=1.
//   4. Back-to-back 8 ops with out_ready=1 -> 8 results, in order, one per cycle, no gaps.
//   5. Backpressure: fill pipeline, hold out_ready=0 for 5 cycles
//      -> in_ready=0, O stable, then all results delivered once, in order.
//   6. Reset mid-stream: rst_n=0 with 2 ops in flight
//      -> out_valid=0 next cycle, those ops never appear. STAGES=1 and STAGES=4 repeat tests 1-4.

Source files
------------

// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined add/subtract, one slice per stage, valid/ready with backpressure and flags
module sumador_segmentado #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic [SW:0]      s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d, v_q, v_d;
  logic ovf_q, ovf_d, zero_q, zero_d, adv;
  assign adv       = !v_q[L] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign O         = r_q[L];
  assign carry     = c_q[L];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  // each stage adds its slice of the carried operands plus the previous stage's carry
  always_comb begin
    a_d[0] = A;
    b_d[0] = sub ? ~B : B;
    s_d[0] = {1'b0, A[SW-1:0]} + {1'b0, b_d[0][SW-1:0]} + (SW+1)'(sub);
    r_d[0] = WIDTH'(s_d[0][SW-1:0]);
    c_d[0] = s_d[0][SW];
    v_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]} + (SW+1)'(c_q[k-1]);
      r_d[k] = r_q[k-1];
      r_d[k][k*SW +: SW] = s_d[k][SW-1:0];
      c_d[k] = s_d[k][SW];
      v_d[k] = v_q[k-1];
    end
    ovf_d  = (a_d[L][WIDTH-1] == b_d[L][WIDTH-1]) & (r_d[L][WIDTH-1] != a_d[L][WIDTH-1]);
    zero_d = r_d[L] == '0;
  end
  // all stages shift together on advance; only valid slots load data so outputs hold through bubbles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          r_q[k] <= r_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end
endmodule

// File: tb/tb_sumador_segmentado.sv
// tb_sumador_segmentado: scoreboard bench over 1-, 2- and 4-stage instances driven in parallel
module tb_sumador_segmentado;
  logic clk, rst_n, in_valid, out_ready, sub;
  logic [31:0] a, b;
  logic rdy [3];
  logic ov [3];
  logic [31:0] o [3];
  logic c [3];
  logic vf [3];
  logic z [3];
  logic [34:0] exp_q [3][$];
  int cmp, bad;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    sumador_segmentado #(.WIDTH(32), .STAGES(g == 0 ? 1 : g == 1 ? 2 : 4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[g]),
      .A(a), .B(b), .sub(sub), .out_valid(ov[g]), .out_ready(out_ready),
      .O(o[g]), .carry(c[g]), .overflow(vf[g]), .zero(z[g]));
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int st(input int i);
    return i == 0 ? 1 : i == 1 ? 2 : 4;
  endfunction

  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] yp;
    logic [32:0] f;
    yp = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yp} + 33'(s);
    return {f[31:0], f[32], (x[31] == yp[31]) && (f[31] != x[31]), f[31:0] == 32'd0};
  endfunction

  // one clock: score the handshakes of the coming edge at negedge, then return 1 time unit after it
  task automatic cycle();
    logic [34:0] e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) exp_q[i].delete();
      else begin
        if (ov[i] && out_ready) begin
          cmp++;
          if (exp_q[i].size() == 0) begin
            bad++;
            $display("FAIL sb_extra stages=%0d got O=%h with no result expected", st(i), o[i]);
          end else begin
            e = exp_q[i].pop_front();
            if ({o[i], c[i], vf[i], z[i]} !== e) begin
              bad++;
              $display("FAIL sb_result stages=%0d got O=%h c=%b v=%b z=%b expected O=%h c=%b v=%b z=%b",
                       st(i), o[i], c[i], vf[i], z[i], e[34:3], e[2], e[1], e[0]);
            end
          end
        end
        if (in_valid && rdy[i]) exp_q[i].push_back(model(a, b, sub));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; a = 32'h1; b = 32'h1; sub = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp++;
      if ({ov[i], o[i], c[i], vf[i], z[i], rdy[i]} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL reset_state stages=%0d got ov=%b O=%h c=%b v=%b z=%b rdy=%b expected 0,0,0,0,0,1",
                 st(i), ov[i], o[i], c[i], vf[i], z[i], rdy[i]);
      end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [5] = '{32'h4, 32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5};
    logic [31:0] vb [5] = '{32'h00400000, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h5};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [34:0] ve [5] = '{{32'h00400004, 3'b000}, {32'h00010000, 3'b000}, {32'h0, 3'b101},
                            {32'h80000000, 3'b010}, {32'h0, 3'b101}};
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      a = va[n]; b = vb[n]; sub = vs[n]; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int j = 1; j <= 5; j++) begin
        for (int i = 0; i < 3; i++) begin
          cmp++;
          if (ov[i] !== (j == st(i))) begin
            bad++;
            $display("FAIL latency vec=%0d stages=%0d cycle=%0d got out_valid=%b expected %b",
                     n, st(i), j, ov[i], j == st(i));
          end
          if (j == st(i)) begin
            cmp++;
            if ({o[i], c[i], vf[i], z[i]} !== ve[n]) begin
              bad++;
              $display("FAIL vector vec=%0d stages=%0d got O=%h cvz=%b%b%b expected O=%h cvz=%b",
                       n, st(i), o[i], c[i], vf[i], z[i], ve[n][34:3], ve[n][2:0]);
            end
          end
        end
        cycle();
      end
    end
  endtask

  task automatic test_back_to_back();
    int first [3];
    int last [3];
    int cnt [3];
    for (int i = 0; i < 3; i++) begin first[i] = -1; last[i] = -1; cnt[i] = 0; end
    out_ready = 1'b1;
    for (int j = 0; j < 14; j++) begin
      in_valid = j < 8;
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      cycle();
      for (int i = 0; i < 3; i++) if (ov[i]) begin
        if (first[i] < 0) first[i] = j;
        last[i] = j;
        cnt[i]++;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp++;
      if (cnt[i] != 8 || last[i] - first[i] != 7) begin
        bad++;
        $display("FAIL back_to_back stages=%0d got %0d results over %0d cycles expected 8 over 8",
                 st(i), cnt[i], last[i] - first[i] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      cycle();
    end
    hold = o[1];
    for (int j = 0; j < 5; j++) begin
      a = $urandom; b = $urandom;
      cycle();
      cmp++;
      if (rdy[1] !== 1'b0 || ov[1] !== 1'b1 || o[1] !== hold) begin
        bad++;
        $display("FAIL stall stages=2 got rdy=%b ov=%b O=%h expected rdy=0 ov=1 O=%h", rdy[1], ov[1], o[1], hold);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b0;
      cycle();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 3; i++) begin
        cmp++;
        if (ov[i] !== 1'b0) begin
          bad++;
          $display("FAIL flush stages=%0d cycle=%0d got out_valid=%b expected 0", st(i), j, ov[i]);
        end
      end
      cycle();
    end
  endtask

  task automatic test_random();
    logic [31:0] sp [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    for (int j = 0; j < 200; j++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : $urandom;
      b = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : $urandom;
      sub = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
  endtask

  task automatic drain();
    for (int j = 0; j < 20 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; j++) cycle();
    for (int i = 0; i < 3; i++) begin
      cmp++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL drain stages=%0d got %0d results outstanding expected 0", st(i), exp_q[i].size());
      end
    end
  endtask

  initial begin
    cmp = 0; bad = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
